// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and 8N1 framing constants.
// Used by both the tx path and the existing rx path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (Rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter: bytes queue in a small FIFO and are shifted out LSB-first
// on a registered tx pin, with back-to-back frames when more bytes are waiting.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic [DATA_BITS-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  BIT_LAST = IDX_W'(DATA_BITS - 1);

    uart_tx_state_t         state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   baud_end;

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign baud_end = (baud_cnt == CNT_LAST);
    // Popping at the end of STOP is what makes consecutive frames gapless.
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= STOP_LVL;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= START;
                        tx    <= START_LVL;
                    end else begin
                        tx    <= STOP_LVL;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                            tx    <= STOP_LVL;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            // shift[1] becomes shift[0] on this same edge
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= START;
                            tx    <= START_LVL;
                        end else begin
                            state <= IDLE;
                            tx    <= STOP_LVL;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= fifo_rdata;
        end else if ((state == DATA) && baud_end) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (4 clocks per bit, 4-entry FIFO): a line monitor
// captures every frame, checked against hand-computed 10-bit frame patterns.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FLEN  = 10 * CPB;

    logic          clk = 1'b0;
    logic          Rst;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int peak     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: a frame starts at the first low sample outside reset.
    logic [FLEN-1:0] mon_frame [64];
    int              mon_start [64];
    logic [FLEN-1:0] mon_samp;
    int              mon_n = 0;
    int              rd_n  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!Rst && tx === 1'b0) begin
                mon_start[mon_n % 64] = cyc;
                for (int k = 0; k < FLEN; k++) begin
                    if (k > 0) @(negedge clk);
                    mon_samp[k] = tx;
                end
                mon_frame[mon_n % 64] = mon_samp;
                mon_n = mon_n + 1;
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit time: [0]=start ... [9]=stop
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FLEN-1:0] expand(input logic [9:0] f);
        logic [FLEN-1:0] r;
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < CPB; c++)
                r[b*CPB + c] = f[b];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    task automatic wait_frames(input int n, input string name);
        int i = 0;
        while ((mon_n - rd_n) < n && i < 2000) begin
            tick();
            i++;
        end
        check({name, "_timeout"}, 64'((mon_n - rd_n) >= n), 64'd1);
    endtask

    task automatic expect_frame(input logic [9:0] f, input string name);
        logic [FLEN-1:0] got = '0;
        if (rd_n < mon_n) begin
            got = mon_frame[rd_n % 64];
            rd_n++;
        end
        check(name, 64'(got), 64'(expand(f)));
    endtask

    task automatic check_gap(input string name);
        check(name, 64'(mon_start[(rd_n + 1) % 64] - mon_start[rd_n % 64]), 64'(FLEN));
    endtask

    // Single byte from idle: latency, busy timing and frame contents.
    task automatic send_one(input logic [7:0] d, input logic [9:0] f, input string name);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
        check({name, "_queued"}, {tx, fifo_count}, {1'b1, CW'(1)});
        tick();
        check({name, "_start"}, {tx, fifo_count}, {1'b0, CW'(0)});
        repeat (FLEN - 1) tick();
        check({name, "_busy_end"}, 64'(busy), 64'd1);
        tick();
        check({name, "_idle"}, {busy, tx}, {1'b0, 1'b1});
        wait_frames(1, name);
        expect_frame(f, {name, "_frame"});
    endtask

    int low_cnt;
    int exp_cnt [6];
    int exp_rdy [6];

    initial begin
        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h81, 10'b1100000010};
        vecs[4] = '{8'hA3, 10'b1101000110};
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        exp_rdy = '{1, 1, 1, 1, 0, 0};

        Rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        Rst = 1'b0;

        low_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({tx, busy, tx_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, CW'(0)}) low_cnt++;
        end
        check("reset_idle_bad_cycles", 64'(low_cnt), 64'd0);
        check("reset_idle_state", {tx, busy, tx_ready, fifo_count}, {1'b1, 1'b0, 1'b1, CW'(0)});

        for (int i = 0; i < 5; i++)
            send_one(vecs[i].data, vecs[i].frame, $sformatf("vec%0d", i));

        // Back-to-back pair pushed on consecutive edges.
        peak     = 0;
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        tick();
        tx_data  = 8'h0F;
        tick();
        tx_valid = 1'b0;
        wait_frames(2, "b2b");
        check_gap("b2b_gap");
        expect_frame(10'b1101000110, "b2b_frame0");
        expect_frame(10'b1000011110, "b2b_frame1");
        check("b2b_peak", 64'(peak), 64'd1);
        repeat (5) tick();
        check("b2b_idle", 64'(busy), 64'd0);

        // Push coinciding with the end-of-STOP pop while two bytes are queued.
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        tick();
        tx_data  = 8'h00;
        tick();
        tx_data  = 8'h5A;
        tick();
        tx_valid = 1'b0;
        check("simul_pre_count", 64'(fifo_count), 64'd2);
        repeat (FLEN - 2) tick();
        check("simul_stop_level", {tx, fifo_count}, {1'b1, CW'(2)});
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        check("simul_count_hold", {tx, fifo_count}, {1'b0, CW'(2)});
        wait_frames(4, "simul");
        check_gap("simul_gap");
        expect_frame(10'b1100000010, "simul_frame0");
        expect_frame(10'b1000000000, "simul_frame1");
        expect_frame(10'b1010110100, "simul_frame2");
        expect_frame(10'b1110000110, "simul_frame3");
        repeat (5) tick();

        // Overfill: six pushes, the sixth arrives while full and is dropped.
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'(i + 1);
            tick();
            check($sformatf("full_push%0d", i + 1), {tx_ready, fifo_count},
                  {1'(exp_rdy[i]), CW'(exp_cnt[i])});
        end
        tx_valid = 1'b0;
        wait_frames(5, "full");
        expect_frame(10'b1000000010, "full_frame1");
        expect_frame(10'b1000000100, "full_frame2");
        expect_frame(10'b1000000110, "full_frame3");
        expect_frame(10'b1000001000, "full_frame4");
        expect_frame(10'b1000001010, "full_frame5");
        repeat (60) tick();
        check("full_no_sixth", 64'(mon_n - rd_n), 64'd0);
        check("full_idle", 64'(busy), 64'd0);

        // Reset during data bit 3 of 0xFF with two bytes waiting.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_data  = 8'h11;
        tick();
        tx_data  = 8'h22;
        tick();
        tx_valid = 1'b0;
        check("rst_pre_count", 64'(fifo_count), 64'd2);
        repeat (15) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("rst_after", {tx, busy, tx_ready, fifo_count}, {1'b1, 1'b0, 1'b1, CW'(0)});
        low_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (tx !== 1'b1 || fifo_count !== CW'(0)) low_cnt++;
        end
        check("rst_quiet_bad_cycles", 64'(low_cnt), 64'd0);
        rd_n = mon_n;
        send_one(8'h3C, 10'b1001111000, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter: the transmit side of the core's 8N1 serial link, paired with the existing rx path.
- Accepts bytes over a valid/ready handshake into a small synchronous FIFO.
- Serialises each byte LSB-first onto the tx pin at a fixed baud rate.
- Sits in the core's clk_50M domain and drives the board-level tx output directly.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2.
- DEPTH, 16, FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  core clock (clk_50M domain)
- Rst  in  1  reset, synchronous, active-high
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data is valid this cycle
- tx_ready  out  1  FIFO can accept a byte; equals !full
- tx  out  1  serial line, registered, idles high
- busy  out  1  high while a frame is on the line or the FIFO is non-empty
- fifo_count  out  $clog2(DEPTH)+1  number of bytes currently queued

Behaviour:
- Reset (Rst sampled high on a clk edge):
  - tx=1, busy=0, fifo_count=0, tx_ready=1.
  - FSM=IDLE; baud counter=0; bit index=0.
  - FIFO pointers are cleared.
  - Reset mid-frame aborts the frame: tx is high the cycle after the reset edge, and queued bytes are discarded.
- Push:
  - Occurs on an edge where tx_valid && tx_ready.
  - The byte is written at the write pointer, and fifo_count increments after that edge.
  - tx_valid while full is ignored; the byte is not stored and no error is raised.
- Pop:
  - Occurs on an edge where the FSM is IDLE or at end-of-STOP, and fifo_count > 0.
  - The head byte loads the shift register, and the FSM enters START.
- Simultaneous push and pop on one edge: fifo_count is unchanged, and both pointers advance.
- FIFO pointers are $clog2(DEPTH)+1 bits with natural wrap; full/empty are decoded from the MSB comparison.
- FSM states:
  - IDLE: tx=1. Pop if non-empty, otherwise stay.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right, index+1. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, pop and go to START if non-empty, else go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
  - The bit boundary is where count == CLKS_PER_BIT-1.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx goes low from edge N+1, i.e. tx falls one cycle after the push edge.
- Frame length is exactly 10*CLKS_PER_BIT cycles from the falling start edge to the end of stop.
- Back-to-back frames have no idle gap between the stop bit and the next start bit.
- busy = (FSM != IDLE) || (fifo_count != 0), combinational from registered state.
- tx is driven from a flop, so no combinational glitches appear on the pin.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t
  - localparams DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, shared with the receiver.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty, count).
  - rdata is first-word-fall-through so a pop loads the head in the same cycle.
- The serialiser FSM and baud counter stay in uart_tx_fifo.

Test Plan:
- Reset idle: Rst=1 for 3 cycles, then release -> tx=1, busy=0, tx_ready=1, fifo_count=0 held for 50 cycles.
- Single byte (CLKS_PER_BIT=4): push 0x55 -> tx falls 1 cycle later; line bits 0,1,0,1,0,1,0,1,0,1 each exactly 4 cycles; busy drops to 0 40 cycles after tx falls.
- Back-to-back: push 0xA3 and 0x0F on consecutive cycles -> two 40-cycle frames with no idle gap; data bits LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; fifo_count peaks at 1.
- Full FIFO (DEPTH=4): push 6 bytes 0x01..0x06 while the first frame is sending -> 0x01 is popped, 0x02..0x05 fill the FIFO, tx_ready=0, 0x06 is dropped; exactly 5 frames 0x01..0x05 are observed.
- Simultaneous push/pop at count=2: push on the end-of-STOP edge -> fifo_count stays 2 and the byte order is preserved.
- Reset mid-frame: assert Rst during DATA bit 3 of 0xFF with 2 bytes queued -> tx=1 next cycle, fifo_count=0, no further frames appear; a new push of 0x3C afterwards transmits correctly.
